// File: rtl/touch_panel_pen_debounce.sv
// PENIRQ conditioning: synchroniser plus qualification FSM producing a clean level and
// press/release strobes. Optional glitch counter enabled by TOUCH_PEN_GLITCH_COUNT_EN.
module touch_panel_pen_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pen_irq_n_pin,
  output logic                pen_irq_n,
  output logic                pen_down_pulse,
  output logic                pen_up_pulse
`ifdef TOUCH_PEN_GLITCH_COUNT_EN
  ,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_count
`endif
);

  // Elaboration-time guards on the legal parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1))
  begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..2^CNT_W-1");
  end
  if (GLITCH_W < 1) begin : g_bad_glitch
    $error("GLITCH_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

  typedef enum logic [1:0] {
    StUp       = 2'd0,
    StDownPend = 2'd1,
    StDown     = 2'd2,
    StUpPend   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;

  // Synchroniser resets to all-ones so a reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pen_irq_n_pin};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StUp;
      cnt_q          <= '0;
      pen_irq_n      <= 1'b1;
      pen_down_pulse <= 1'b0;
      pen_up_pulse   <= 1'b0;
    end else begin
      pen_down_pulse <= 1'b0;
      pen_up_pulse   <= 1'b0;
      unique case (state_q)
        StUp: begin
          if (!s) begin
            state_q <= StDownPend;
            cnt_q   <= OneCnt;
          end
        end
        StDownPend: begin
          if (s) begin
            state_q <= StUp;
            cnt_q   <= '0;
          end else if (cnt_q == TermCnt) begin
            state_q        <= StDown;
            cnt_q          <= '0;
            pen_irq_n      <= 1'b0;
            pen_down_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + OneCnt;
          end
        end
        StDown: begin
          if (s) begin
            state_q <= StUpPend;
            cnt_q   <= OneCnt;
          end
        end
        StUpPend: begin
          if (!s) begin
            state_q <= StDown;
            cnt_q   <= '0;
          end else if (cnt_q == TermCnt) begin
            state_q      <= StUp;
            cnt_q        <= '0;
            pen_irq_n    <= 1'b1;
            pen_up_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + OneCnt;
          end
        end
        default: begin
          state_q <= StUp;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef TOUCH_PEN_GLITCH_COUNT_EN
  localparam logic [GLITCH_W-1:0] GlitchMax = '1;

  logic reject;

  // A pending qualification that falls back to its stable state is a rejected glitch.
  assign reject = ((state_q == StDownPend) && s) || ((state_q == StUpPend) && !s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_count <= '0;
    end else if (glitch_clr) begin
      glitch_count <= '0;
    end else if (reject && (glitch_count != GlitchMax)) begin
      glitch_count <= glitch_count + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_touch_panel_pen_debounce.sv
// Directed bench for touch_panel_pen_debounce; pulse events are checked through a scoreboard.
module tb_touch_panel_pen_debounce;

  localparam int unsigned Deb  = 8;
  localparam int unsigned Sync = 2;
  localparam int unsigned Lat  = Sync + Deb; // edges from drive-time count to output edge

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pen_irq_n_pin = 1'b1;
  logic pen_irq_n;
  logic pen_down_pulse;
  logic pen_up_pulse;
`ifdef TOUCH_PEN_GLITCH_COUNT_EN
  logic       glitch_clr = 1'b0;
  logic [7:0] glitch_count;
`endif

  touch_panel_pen_debounce #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (16),
    .SYNC_STAGES    (Sync),
    .GLITCH_W       (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pen_irq_n_pin (pen_irq_n_pin),
    .pen_irq_n     (pen_irq_n),
    .pen_down_pulse(pen_down_pulse),
    .pen_up_pulse  (pen_up_pulse)
`ifdef TOUCH_PEN_GLITCH_COUNT_EN
    ,
    .glitch_clr    (glitch_clr),
    .glitch_count  (glitch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    bit          down;
  } ev_t;

  ev_t         sb_q[$];
  ev_t         ev;
  int unsigned edges = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) edges <= edges + 1;

  // Any strobe must match the oldest expected event in edge, kind and resulting level.
  always @(negedge clk) begin
    if (pen_down_pulse || pen_up_pulse) begin
      tests++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_pulse: got down=%0b up=%0b at edge %0d, want no pulse",
               pen_down_pulse, pen_up_pulse, edges);
      end
      if (sb_q.size() != 0) begin
        ev = sb_q.pop_front();
        tests++;
        assert (edges === ev.at) else begin
          fails++;
          $error("FAIL pulse_edge: got edge %0d, want %0d", edges, ev.at);
        end
        tests++;
        assert ({pen_down_pulse, pen_up_pulse} === {ev.down, ~ev.down}) else begin
          fails++;
          $error("FAIL pulse_kind: got down=%0b up=%0b, want down=%0b up=%0b",
                 pen_down_pulse, pen_up_pulse, ev.down, ~ev.down);
        end
        tests++;
        assert (pen_irq_n === ~ev.down) else begin
          fails++;
          $error("FAIL level_at_pulse: got pen_irq_n=%0b, want %0b", pen_irq_n, ~ev.down);
        end
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0b, want %0b", tag, got, want);
    end
  endtask

  task automatic check_sb_empty(input string tag);
    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL %s: got %0d pending events, want 0", tag, sb_q.size());
    end
  endtask

`ifdef TOUCH_PEN_GLITCH_COUNT_EN
  task automatic check_gc(input string tag, input logic [7:0] want);
    tests++;
    assert (glitch_count === want) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, glitch_count, want);
    end
  endtask
`endif

  // Drive the pin at a negedge and, if it should be accepted, queue the expected event.
  task automatic drive_pin(input logic v, input bit expect_ev);
    pen_irq_n_pin = v;
    if (expect_ev) sb_q.push_back('{at: edges + Lat, down: (v == 1'b0)});
  endtask

  initial begin
    // Reset values.
    wait_neg(3);
    check_bit("reset_irq", pen_irq_n, 1'b1);
    check_bit("reset_down_pulse", pen_down_pulse, 1'b0);
    check_bit("reset_up_pulse", pen_up_pulse, 1'b0);
`ifdef TOUCH_PEN_GLITCH_COUNT_EN
    check_gc("reset_glitch_count", 8'd0);
`endif
    reset_n = 1'b1;
    wait_neg(5);

    // Clean press: unchanged one edge early, low at the event edge, strobe for one cycle.
    drive_pin(1'b0, 1'b1);
    wait_neg(Lat - 1);
    check_bit("press_not_early", pen_irq_n, 1'b1);
    wait_neg(1);
    check_bit("press_level", pen_irq_n, 1'b0);
    wait_neg(1);
    check_bit("press_pulse_single", pen_down_pulse, 1'b0);
    check_sb_empty("press_sb");

    // Clean release.
    wait_neg(3);
    drive_pin(1'b1, 1'b1);
    wait_neg(Lat - 1);
    check_bit("release_not_early", pen_irq_n, 1'b0);
    wait_neg(1);
    check_bit("release_level", pen_irq_n, 1'b1);
    wait_neg(1);
    check_bit("release_pulse_single", pen_up_pulse, 1'b0);
    check_sb_empty("release_sb");

    // Bounce: low 5, high 1, then low and held.
    wait_neg(3);
    drive_pin(1'b0, 1'b0);
    wait_neg(5);
    drive_pin(1'b1, 1'b0);
    wait_neg(1);
    drive_pin(1'b0, 1'b1);
    wait_neg(Lat - 1);
    check_bit("bounce_not_early", pen_irq_n, 1'b1);
    wait_neg(2);
    check_bit("bounce_level", pen_irq_n, 1'b0);
    check_sb_empty("bounce_sb");
`ifdef TOUCH_PEN_GLITCH_COUNT_EN
    check_gc("bounce_glitch_count", 8'd1);
`endif
    drive_pin(1'b1, 1'b1);
    wait_neg(Lat + 2);
    check_sb_empty("bounce_release_sb");

    // Short spike: rejected, no output change.
    drive_pin(1'b0, 1'b0);
    wait_neg(3);
    drive_pin(1'b1, 1'b0);
    wait_neg(20);
    check_bit("spike_level", pen_irq_n, 1'b1);
    check_sb_empty("spike_sb");
`ifdef TOUCH_PEN_GLITCH_COUNT_EN
    check_gc("spike_glitch_count", 8'd2);
`endif

    // Many spikes drive the glitch counter into saturation.
    for (int i = 0; i < 300; i++) begin
      drive_pin(1'b0, 1'b0);
      wait_neg(3);
      drive_pin(1'b1, 1'b0);
      wait_neg(3);
    end
    wait_neg(5);
    check_bit("spikes_level", pen_irq_n, 1'b1);
    check_sb_empty("spikes_sb");
`ifdef TOUCH_PEN_GLITCH_COUNT_EN
    check_gc("glitch_saturate", 8'd255);
    glitch_clr = 1'b1;
    wait_neg(1);
    glitch_clr = 1'b0;
    check_gc("glitch_clear", 8'd0);
`endif

    // Reset mid-DOWN with the pin held low, then full re-qualification.
    drive_pin(1'b0, 1'b1);
    wait_neg(Lat + 2);
    check_bit("pre_reset_down", pen_irq_n, 1'b0);
    check_sb_empty("pre_reset_sb");
    reset_n = 1'b0;
    #1;
    check_bit("async_reset_irq", pen_irq_n, 1'b1);
    check_bit("async_reset_pulse", pen_down_pulse | pen_up_pulse, 1'b0);
    wait_neg(3);
    reset_n = 1'b1;
    sb_q.push_back('{at: edges + Lat, down: 1'b1});
    wait_neg(Lat - 1);
    check_bit("requal_not_early", pen_irq_n, 1'b1);
    wait_neg(1);
    check_bit("requal_level", pen_irq_n, 1'b0);
    wait_neg(2);
    check_sb_empty("requal_sb");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/touch_panel_pen_debounce.md
# touch_panel_pen_debounce

Upstream conditioning stage for the resistive touch panel's active-low PENIRQ pin. It synchronises the raw asynchronous pin into the system clock domain and rejects contact bounce and noise spikes with a qualification state machine. It drives a clean, glitch-free `pen_irq_n` into the pen-IRQ PIO's `in_port`, where the PIO's falling-edge capture raises the CPU interrupt. It also produces one-cycle press/release strobes for hardware consumers such as the touch ADC sequencer.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronised samples required to accept a level change (1 ms at 50 MHz); legal range 2..2^CNT_W-1.
- `CNT_W`, 16: width of the qualification counter.
- `SYNC_STAGES`, 2: synchroniser flop count; legal range 2..4.
- `GLITCH_W`, 8: width of the glitch counter (used only with the macro in Configuration).

Ports:
- `clk` input 1: system clock. One clock; reset is asynchronous and active-low.
- `reset_n` input 1: asynchronous active-low reset.
- `pen_irq_n_pin` input 1: raw PENIRQ pin from the touch controller, asynchronous, 0 = pen down.
- `pen_irq_n` output 1: debounced level, registered, 0 = pen down; drives the PIO `in_port`.
- `pen_down_pulse` output 1: one-cycle strobe on an accepted press.
- `pen_up_pulse` output 1: one-cycle strobe on an accepted release.
- `glitch_clr` input 1: synchronous clear of `glitch_count` (macro only).
- `glitch_count` output GLITCH_W: saturating count of rejected transitions (macro only).

## Operation
- Synchroniser: a chain of SYNC_STAGES flops. All flops reset to 1 (pen up). Its output is the sample `s`.
- The FSM has 4 states, UP, DOWN_PEND, DOWN and UP_PEND. Reset state is UP.
- UP: if `s`=0, go to DOWN_PEND with `cnt`=1. Otherwise stay in UP.
- DOWN_PEND:
  - If `s`=1, the press is rejected as a glitch. Return to UP. `pen_irq_n` is unchanged.
  - Else if `cnt`=DEBOUNCE_CYCLES-1, go to DOWN. Register `pen_irq_n`=0 and assert `pen_down_pulse` on the same edge.
  - Else increment `cnt`.
- DOWN: mirror of UP. If `s`=1, go to UP_PEND with `cnt`=1.
- UP_PEND: mirror of DOWN_PEND.
  - A 0 sample returns to DOWN as a glitch.
  - At terminal count, go to UP with `pen_irq_n`=1 and `pen_up_pulse`=1.
- `cnt` is CNT_W bits wide and is never wrapped. The terminal compare ends qualification before any overflow.
- `pen_down_pulse` and `pen_up_pulse` are mutually exclusive. Each lasts exactly one cycle per accepted transition.
- Reset behaviour:
  - `reset_n` low, at any time including mid-qualification, forces `pen_irq_n`=1, both pulses 0, state UP, `cnt`=0 and the synchroniser to all-ones.
  - After release with the pin still held low, a full re-qualification runs. It produces a fresh falling edge and `pen_down_pulse`, so the PIO recaptures the press.

## Timing
- A clean level change on `pen_irq_n_pin` before rising edge k reaches `s` after edge k+SYNC_STAGES-1.
- `pen_irq_n` and the matching pulse change at edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES. Total latency is SYNC_STAGES+DEBOUNCE_CYCLES-1 edges.
- Bounce on `s` shorter than DEBOUNCE_CYCLES consecutive samples produces no output change. Each bounce restarts qualification from `cnt`=1.
- Press and release are symmetric; both use identical latency.
- All outputs are registered. There is no combinational path from `pen_irq_n_pin` to any output.

## Configuration
- `TOUCH_PEN_GLITCH_COUNT_EN` defined:
  - `glitch_count` increments on every PEND→stable-state rejection and saturates at 2^GLITCH_W-1.
  - `glitch_clr` zeroes it on the next edge. Clear wins over a simultaneous increment.
  - Reset value is 0.
- Not defined: the `glitch_clr` and `glitch_count` ports and all counting logic are absent. The rest of the behaviour is unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and SYNC_STAGES=2.
- Reset values: hold `reset_n`=0 → `pen_irq_n`=1, both pulses 0, `glitch_count`=0.
- Clean press: drive the pin to 0 before edge 10 and hold it → `pen_irq_n` falls at edge 19, `pen_down_pulse`=1 for that single cycle only.
- Clean release: from DOWN, drive the pin to 1 and hold it → `pen_irq_n` rises 9 edges later with a single `pen_up_pulse`.
- Bounce: pin low for 5 cycles, high for 1, then low and held → no change until 9 edges after the final fall; `glitch_count`=1.
- Short spike: pin low for 3 cycles, then high → `pen_irq_n` stays 1 and no pulses. `glitch_count` saturates at 255 after 300 spikes; `glitch_clr` then returns it to 0.
- Reset mid-DOWN with the pin held low: assert `reset_n` → `pen_irq_n`=1 immediately. Release → `pen_irq_n` falls again 9 edges after release, with `pen_down_pulse`.
